// File: rtl/seg7_pkg.sv
// Shared constants, types and glyph lookup for the 7-segment receive path.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    // Active-low glyphs, bit order g..a
    localparam logic [SEG_W-1:0] SEG7_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG7_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG7_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG7_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG7_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG7_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG7_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG7_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG7_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG7_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG7_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG7_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG7_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG7_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG7_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG7_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG7_BLANK = 7'h7F;

    typedef logic [0:0] seg7_state_t;
    localparam seg7_state_t LOCKED = 1'b0;
    localparam seg7_state_t SETTLE = 1'b1;

    typedef struct packed {
        logic             legal;
        logic [NIB_W-1:0] nibble;
    } seg7_dec_t;

    function automatic seg7_dec_t seg7_lookup(input logic [SEG_W-1:0] seg);
        seg7_dec_t d;
        d = '{legal: 1'b1, nibble: 4'h0};
        case (seg)
            SEG7_0:  d.nibble = 4'h0;
            SEG7_1:  d.nibble = 4'h1;
            SEG7_2:  d.nibble = 4'h2;
            SEG7_3:  d.nibble = 4'h3;
            SEG7_4:  d.nibble = 4'h4;
            SEG7_5:  d.nibble = 4'h5;
            SEG7_6:  d.nibble = 4'h6;
            SEG7_7:  d.nibble = 4'h7;
            SEG7_8:  d.nibble = 4'h8;
            SEG7_9:  d.nibble = 4'h9;
            SEG7_A:  d.nibble = 4'hA;
            SEG7_B:  d.nibble = 4'hB;
            SEG7_C:  d.nibble = 4'hC;
            SEG7_D:  d.nibble = 4'hD;
            SEG7_E:  d.nibble = 4'hE;
            SEG7_F:  d.nibble = 4'hF;
            default: d.legal  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph classifier: legal digit, blank, or neither.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             legal_c,
    output logic             blank_c,
    output logic [NIB_W-1:0] nibble_c
);

    seg7_dec_t dec;

    always_comb begin
        dec      = seg7_lookup(seg);
        legal_c  = dec.legal;
        nibble_c = dec.nibble;
        blank_c  = (seg == SEG7_BLANK);
    end

endmodule

// File: rtl/seg7_rx_decoder.sv
// Synchronises an active-low segment bus, debounces it and recovers the hex digit.
module seg7_rx_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEG_W-1:0] seg_in,
    output logic [NIB_W-1:0] hex_out,
    output logic             hex_valid,
    output logic             new_digit,
    output logic             bad_pattern,
    output logic [CNT_W-1:0] change_count
);

    localparam int unsigned STB_W = 8;
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

    seg7_state_t      state, state_nxt;
    logic [SEG_W-1:0] s1, s2;
    logic [SEG_W-1:0] last, last_nxt;
    logic [SEG_W-1:0] acc, acc_nxt;
    logic [STB_W-1:0] cnt, cnt_nxt;
    logic [NIB_W-1:0] hex_nxt;
    logic             valid_nxt, new_nxt, bad_nxt;
    logic [CNT_W-1:0] count_nxt;

    logic             last_legal_c, last_blank_c;
    logic [NIB_W-1:0] last_nibble_c;

    seg7_glyph_decode u_decode (
        .seg      (last),
        .legal_c  (last_legal_c),
        .blank_c  (last_blank_c),
        .nibble_c (last_nibble_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1           <= SEG7_BLANK;
            s2           <= SEG7_BLANK;
            last         <= SEG7_BLANK;
            acc          <= SEG7_BLANK;
            cnt          <= '0;
            state        <= LOCKED;
            hex_out      <= '0;
            hex_valid    <= 1'b0;
            new_digit    <= 1'b0;
            bad_pattern  <= 1'b0;
            change_count <= '0;
        end else begin
            s1           <= seg_in;
            s2           <= s1;
            last         <= last_nxt;
            acc          <= acc_nxt;
            cnt          <= cnt_nxt;
            state        <= state_nxt;
            hex_out      <= hex_nxt;
            hex_valid    <= valid_nxt;
            new_digit    <= new_nxt;
            bad_pattern  <= bad_nxt;
            change_count <= count_nxt;
        end
    end

    // Next-state, debounce counter and accept logic
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        hex_nxt   = hex_out;
        valid_nxt = hex_valid;
        new_nxt   = 1'b0;
        bad_nxt   = 1'b0;
        count_nxt = change_count;

        case (state)
            LOCKED: begin
                if (s2 != last) begin
                    last_nxt  = s2;
                    cnt_nxt   = '0;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (s2 != last) begin
                    last_nxt = s2;
                    cnt_nxt  = '0;
                end else if (cnt != STB_LAST) begin
                    cnt_nxt = cnt + STB_W'(1);
                end else begin
                    state_nxt = LOCKED;
                    // A pattern equal to the one already accepted is a returned glitch
                    if (last != acc) begin
                        acc_nxt = last;
                        if (last_legal_c) begin
                            hex_nxt   = last_nibble_c;
                            valid_nxt = 1'b1;
                            if (!hex_valid || (last_nibble_c != hex_out)) begin
                                new_nxt   = 1'b1;
                                count_nxt = change_count + CNT_W'(1);
                            end
                        end else begin
                            valid_nxt = 1'b0;
                            bad_nxt   = !last_blank_c;
                        end
                    end
                end
            end
            default: state_nxt = LOCKED;
        endcase
    end

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Randomised bench for seg7_rx_decoder against a run-length reference model.
module tb_seg7_rx_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned CW     = 8;

    logic          clk;
    logic          reset;
    logic [6:0]    seg_in;
    logic [3:0]    hex_out;
    logic          hex_valid;
    logic          new_digit;
    logic          bad_pattern;
    logic [CW-1:0] change_count;

    seg7_rx_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .hex_out      (hex_out),
        .hex_valid    (hex_valid),
        .new_digit    (new_digit),
        .bad_pattern  (bad_pattern),
        .change_count (change_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    logic [6:0] glyph [16];

    // Reference model: the bus is accepted once the value seen two edges late
    // has persisted for STABLE+1 consecutive edges.
    logic [6:0]    m_s1, m_s2, m_run_val, m_acc;
    int            m_run;
    logic [3:0]    m_hex;
    logic          m_valid, m_new, m_bad;
    logic [CW-1:0] m_cnt;

    task automatic model_reset();
        m_s1 = 7'h7F; m_s2 = 7'h7F; m_run_val = 7'h7F; m_run = STABLE + 1;
        m_acc = 7'h7F; m_hex = 4'h0; m_valid = 1'b0; m_new = 1'b0; m_bad = 1'b0;
        m_cnt = '0;
    endtask

    task automatic model_accept(input logic [6:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < 16; i++) if (glyph[i] == v) idx = i;
        if (v == m_acc) return;
        m_acc = v;
        if (idx >= 0) begin
            if (!m_valid || m_hex != 4'(idx)) begin
                m_new = 1'b1;
                m_cnt = m_cnt + 1'b1;
            end
            m_hex   = 4'(idx);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
            m_bad   = (v != 7'h7F);
        end
    endtask

    task automatic model_edge(input logic [6:0] bus);
        logic [6:0] x;
        x = m_s2;
        m_s2 = m_s1;
        m_s1 = bus;
        m_new = 1'b0;
        m_bad = 1'b0;
        if (x == m_run_val) begin
            if (m_run <= int'(STABLE)) begin
                m_run++;
                if (m_run == int'(STABLE) + 1) model_accept(x);
            end
        end else begin
            m_run_val = x;
            m_run     = 1;
        end
    endtask

    task automatic check_outputs();
        chk("hex_out",      32'(hex_out),      32'(m_hex));
        chk("hex_valid",    32'(hex_valid),    32'(m_valid));
        chk("new_digit",    32'(new_digit),    32'(m_new));
        chk("bad_pattern",  32'(bad_pattern),  32'(m_bad));
        chk("change_count", 32'(change_count), 32'(m_cnt));
        if (new_digit && bad_pattern) chk("pulse_excl", 32'(1), 32'(0));
    endtask

    // Drive one value for one clock, advance the model, then compare away from the edge
    task automatic step(input logic [6:0] v);
        seg_in = v;
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge(v);
        #1;
        check_outputs();
    endtask

    task automatic hold(input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

        reset  = 1'b0;
        seg_in = 7'h7F;
        model_reset();
        #12;
        check_outputs();
        hold(7'h7F, 2);
        reset = 1'b1;

        // Idle blank bus
        hold(7'h7F, 50);
        chk("idle_valid", 32'(hex_valid), 32'(0));
        chk("idle_count", 32'(change_count), 32'(0));

        // Digit 2, then a short glitch to 3, then a real 3
        hold(glyph[2], 12);
        chk("d2_hex", 32'(hex_out), 32'(2));
        chk("d2_count", 32'(change_count), 32'(1));
        hold(glyph[3], 3);
        hold(glyph[2], 10);
        chk("glitch_count", 32'(change_count), 32'(1));
        hold(glyph[3], 10);
        chk("d3_hex", 32'(hex_out), 32'(3));
        chk("d3_count", 32'(change_count), 32'(2));

        // Illegal pattern then back to 3
        hold(7'b1010101, 10);
        chk("ill_valid", 32'(hex_valid), 32'(0));
        chk("ill_hex", 32'(hex_out), 32'(3));
        hold(glyph[3], 10);
        chk("re3_valid", 32'(hex_valid), 32'(1));
        chk("re3_count", 32'(change_count), 32'(3));

        // Fresh reset then 17 passes over all glyphs to wrap the counter
        reset = 1'b0;
        hold(7'h7F, 2);
        reset = 1'b1;
        hold(7'h7F, 5);
        for (int p = 0; p < 17; p++)
            for (int g = 0; g < 16; g++) hold(glyph[g], 10);
        chk("wrap_count", 32'(change_count), 32'(16));
        chk("wrap_hex", 32'(hex_out), 32'(15));

        // Randomised traffic: legal glyphs, blanks, arbitrary patterns, short holds
        for (int k = 0; k < 300; k++) begin
            int r;
            logic [6:0] v;
            r = int'($urandom_range(0, 9));
            if (r < 6)      v = glyph[$urandom_range(0, 15)];
            else if (r < 8) v = 7'h7F;
            else            v = 7'($urandom);
            hold(v, int'($urandom_range(1, 8)));
        end

        // Async reset two cycles into SETTLE on F
        hold(7'h7F, 10);
        hold(glyph[15], 4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_hex", 32'(hex_out), 32'(0));
        chk("async_valid", 32'(hex_valid), 32'(0));
        chk("async_count", 32'(change_count), 32'(0));
        model_reset();
        hold(glyph[15], 2);
        reset = 1'b1;
        hold(glyph[15], 8);
        chk("rel_hex", 32'(hex_out), 32'(15));
        chk("rel_valid", 32'(hex_valid), 32'(1));
        chk("rel_count", 32'(change_count), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
